// File: rtl/prbs_bert_ctrl.sv
// PRBS bit-error-rate test sequencer and checker around a TX and a REF PRBS generator.
// Optional single-bit error injection is enabled with `define PRBS_BERT_ERR_INJECT_EN.
module prbs_bert_ctrl #(
  parameter int WIDTH         = 17,
  parameter int CNT_W         = 32,
  parameter int LOCK_THRESH   = 8,
  parameter int LOSS_THRESH   = 4,
  parameter int DRAIN_TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] num_words,
`ifdef PRBS_BERT_ERR_INJECT_EN
  input  logic             inject,
`endif
  output logic             tx_en,
  output logic             tx_init,
  output logic             tx_valid,
  output logic             ref_en,
  output logic             ref_init,
  input  logic [WIDTH-1:0] ref_data,
  input  logic             rx_valid,
  input  logic [WIDTH-1:0] rx_data,
  output logic             busy,
  output logic             done,
  output logic             locked,
  output logic             lock_lost,
  output logic             timeout,
  output logic [CNT_W-1:0] tx_count,
  output logic [CNT_W-1:0] rx_count,
  output logic [CNT_W-1:0] word_errs,
  output logic [CNT_W-1:0] bit_errs
);

  localparam int PC_W = $clog2(WIDTH + 1);
  localparam int LK_W = $clog2(LOCK_THRESH + 1);
  localparam int LS_W = $clog2(LOSS_THRESH + 1);
  localparam int DT_W = $clog2(DRAIN_TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_RUN, S_DRAIN, S_DONE} state_t;
  state_t state, nxt;

  logic [CNT_W-1:0] nw_q, en_cnt;
  logic [WIDTH-1:0] rx_q, diff;
  logic             cmp_vld, checking, compare, word_err, loss, last_word;
  logic             idle_like, drain_clean, drain_to, inj_hit;
  logic [LK_W-1:0]  clean_run;
  logic [LS_W-1:0]  err_run;
  logic [DT_W-1:0]  drain_cnt;
  logic [CNT_W:0]   bit_sum;

  function automatic logic [PC_W-1:0] popcnt(input logic [WIDTH-1:0] v);
    logic [PC_W-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) c = c + PC_W'(v[i]);
    return c;
  endfunction

`ifdef PRBS_BERT_ERR_INJECT_EN
  logic inj_armed;
  assign inj_hit = inj_armed;

  // Armed flag consumes on the next compare; pulses while armed are absorbed.
  always_ff @(posedge clk) begin
    if (reset)                    inj_armed <= 1'b0;
    else if (compare && inj_armed) inj_armed <= 1'b0;
    else if (inject)              inj_armed <= 1'b1;
  end
`else
  assign inj_hit = 1'b0;
`endif

  assign idle_like   = (state == S_IDLE) || (state == S_DONE);
  assign checking    = (state == S_RUN) || (state == S_DRAIN);
  assign busy        = !idle_like;
  assign compare     = cmp_vld && checking;
  assign diff        = (rx_q ^ ref_data) ^ {{(WIDTH-1){1'b0}}, inj_hit};
  assign word_err    = compare && (diff != '0);
  assign loss        = word_err && locked && (err_run == LS_W'(LOSS_THRESH - 1));
  assign last_word   = (nw_q != '0) && (en_cnt + CNT_W'(1) == nw_q);
  // Drain completes only once nothing is left in flight on either side.
  assign drain_clean = !cmp_vld && !tx_valid && (rx_count == tx_count);
  assign drain_to    = (drain_cnt == DT_W'(DRAIN_TIMEOUT - 1));
  assign bit_sum     = {1'b0, bit_errs} + (CNT_W+1)'(popcnt(diff));
  assign ref_en      = (state == S_INIT) || (checking && rx_valid);

  always_comb begin
    nxt      = state;
    tx_en    = 1'b0;
    tx_init  = 1'b0;
    ref_init = 1'b0;
    case (state)
      S_IDLE, S_DONE: if (start) nxt = S_INIT;
      S_INIT: begin
        tx_en    = 1'b1;
        tx_init  = 1'b1;
        ref_init = 1'b1;
        nxt      = S_RUN;
      end
      S_RUN: begin
        if (stop) nxt = S_DRAIN;
        else begin
          tx_en = 1'b1;
          if (last_word || loss) nxt = S_DRAIN;
        end
      end
      S_DRAIN: if (drain_clean || drain_to) nxt = S_DONE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      done      <= 1'b0;
      tx_valid  <= 1'b0;
      cmp_vld   <= 1'b0;
      rx_q      <= '0;
      nw_q      <= '0;
      en_cnt    <= '0;
      drain_cnt <= '0;
      clean_run <= '0;
      err_run   <= '0;
      locked    <= 1'b0;
      lock_lost <= 1'b0;
      timeout   <= 1'b0;
      tx_count  <= '0;
      rx_count  <= '0;
      word_errs <= '0;
      bit_errs  <= '0;
    end else begin
      state    <= nxt;
      done     <= (nxt == S_DONE) && (state != S_DONE);
      tx_valid <= tx_en && (state == S_RUN);
      rx_q     <= rx_data;
      cmp_vld  <= rx_valid && checking;
      if (idle_like && start) begin
        nw_q      <= num_words;
        en_cnt    <= '0;
        drain_cnt <= '0;
        clean_run <= '0;
        err_run   <= '0;
        locked    <= 1'b0;
        lock_lost <= 1'b0;
        timeout   <= 1'b0;
        tx_count  <= '0;
        rx_count  <= '0;
        word_errs <= '0;
        bit_errs  <= '0;
      end else begin
        if (tx_en && state == S_RUN) en_cnt <= en_cnt + CNT_W'(1);
        if (tx_valid) tx_count <= tx_count + CNT_W'(1);
        if (state == S_DRAIN) begin
          drain_cnt <= drain_cnt + DT_W'(1);
          if (drain_to && !drain_clean) timeout <= 1'b1;
        end
        if (compare) begin
          rx_count <= rx_count + CNT_W'(1);
          if (word_err) begin
            if (word_errs != '1) word_errs <= word_errs + CNT_W'(1);
            bit_errs  <= bit_sum[CNT_W] ? '1 : bit_sum[CNT_W-1:0];
            clean_run <= '0;
            if (loss) begin
              locked    <= 1'b0;
              lock_lost <= 1'b1;
              err_run   <= '0;
            end else if (locked) begin
              err_run <= err_run + LS_W'(1);
            end
          end else begin
            err_run <= '0;
            if (!locked) begin
              if (clean_run == LK_W'(LOCK_THRESH - 1)) begin
                locked    <= 1'b1;
                clean_run <= '0;
              end else begin
                clean_run <= clean_run + LK_W'(1);
              end
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_prbs_bert_ctrl.sv
// Bench for prbs_bert_ctrl: PRBS generator models, 5-cycle loopback with per-word
// corruption masks, and an array-walking reference model for error and lock results.
module tb_prbs_bert_ctrl;
  localparam int W  = 17;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          reset, start, stop;
  logic [CW-1:0] num_words;
  logic          tx_en, tx_init, tx_valid, ref_en, ref_init, rx_valid;
  logic [W-1:0]  ref_data, rx_data;
  logic          busy, done, locked, lock_lost, timeout;
  logic [CW-1:0] tx_count, rx_count, word_errs, bit_errs;
`ifdef PRBS_BERT_ERR_INJECT_EN
  logic          inject = 1'b0;
`endif

  int ncmp = 0, nfail = 0;

  always #5 clk = ~clk;

  prbs_bert_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .num_words(num_words),
`ifdef PRBS_BERT_ERR_INJECT_EN
    .inject(inject),
`endif
    .tx_en(tx_en), .tx_init(tx_init), .tx_valid(tx_valid),
    .ref_en(ref_en), .ref_init(ref_init), .ref_data(ref_data),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .busy(busy), .done(done), .locked(locked), .lock_lost(lock_lost), .timeout(timeout),
    .tx_count(tx_count), .rx_count(rx_count), .word_errs(word_errs), .bit_errs(bit_errs)
  );

  // Environment: generator pair, loopback line with corruption masks
  logic [W-1:0] seed_r = 17'h1ACE1;
  logic [W-1:0] txd = '0, refd = '0;
  logic [W-1:0] mask [0:1023];
  logic [W-1:0] pd [5];
  logic [4:0]   pv = '0;
  logic         rx_block = 1'b0;
  int           widx = 0;

  function automatic logic [W-1:0] lfsr_nx(input logic [W-1:0] s);
    return {s[W-2:0], s[16] ^ s[13]};
  endfunction

  always @(posedge clk) begin
    if (tx_en)  txd  <= tx_init  ? seed_r : lfsr_nx(txd);
    if (ref_en) refd <= ref_init ? seed_r : lfsr_nx(refd);
    if (tx_en && tx_init) widx <= 0;
    else if (tx_valid)    widx <= widx + 1;
    pv    <= {pv[3:0], tx_valid && !rx_block};
    pd[0] <= txd ^ ((widx < 1024) ? mask[widx] : '0);
    for (int i = 1; i < 5; i++) pd[i] <= pd[i-1];
  end

  assign ref_data = refd;
  assign rx_valid = pv[4];
  assign rx_data  = pd[4];

  // Per-burst observation counters
  logic mon_clr = 1'b1;
  int   init_cyc, done_cnt, lock_rx, post_fall_txen;
  logic fall_seen, fall_txen, lk_prev;

  always @(negedge clk) begin
    if (mon_clr) begin
      init_cyc = 0; done_cnt = 0; lock_rx = -1; post_fall_txen = 0;
      fall_seen = 0; fall_txen = 1; lk_prev = 0;
    end else begin
      if (done) done_cnt++;
      if (tx_en && tx_init && ref_en && ref_init) init_cyc++;
      if (busy) begin
        if (locked && !lk_prev && lock_rx < 0) lock_rx = int'(rx_count);
        if (!locked && lk_prev && !fall_seen) begin
          fall_seen = 1; fall_txen = tx_en;
        end else if (fall_seen && tx_en) post_fall_txen++;
        lk_prev = locked;
      end else lk_prev = 0;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: walk the word sequence applying the lock/loss rules
  task automatic model(input int n, output int we, output int be, output logic lk, output logic lost);
    int clean, errs;
    we = 0; be = 0; lk = 0; lost = 0; clean = 0; errs = 0;
    for (int i = 0; i < n; i++) begin
      if (mask[i] != '0) begin
        we++; be += $countones(mask[i]); clean = 0;
        if (lk) begin
          errs++;
          if (errs == 4) begin lk = 0; lost = 1; break; end
        end
      end else begin
        errs = 0;
        if (!lk) begin clean++; if (clean == 8) lk = 1; end
      end
    end
  endtask

  task automatic clear_masks();
    for (int i = 0; i < 1024; i++) mask[i] = '0;
  endtask

  task automatic run_burst(input int n, input bit stop_too, input int busy_start_at, input int inj_at);
    int cyc;
    mon_clr = 1'b1;
    @(negedge clk);
    seed_r = W'($urandom_range(1, 131071));
    num_words = CW'(n); start = 1'b1; stop = stop_too; mon_clr = 1'b0;
    cyc = 0;
    while (!done && cyc < n + 200) begin
      @(negedge clk);
      cyc++;
      stop  = 1'b0;
      start = (cyc == busy_start_at);
`ifdef PRBS_BERT_ERR_INJECT_EN
      inject = (inj_at > 0) && (cyc == inj_at || cyc == inj_at + 1);
`endif
    end
    start = 1'b0;
`ifdef PRBS_BERT_ERR_INJECT_EN
    inject = 1'b0;
`endif
    check("done_reached", done, 1);
    repeat (3) @(negedge clk);
    check("done_pulses", done_cnt, 1);
    check("busy_after", busy, 0);
    check("init_cycles", init_cyc, 1);
  endtask

  task automatic check_burst(input string tag, input int n, input int extra_we, input int extra_be);
    int we, be; logic lk, lost;
    model(n, we, be, lk, lost);
    check({tag, ".tx_count"}, tx_count, n);
    check({tag, ".rx_count"}, rx_count, n);
    check({tag, ".word_errs"}, word_errs, we + extra_we);
    check({tag, ".bit_errs"}, bit_errs, be + extra_be);
    check({tag, ".locked"}, locked, lk);
    check({tag, ".lock_lost"}, lock_lost, lost);
    check({tag, ".timeout"}, timeout, 0);
  endtask

  initial begin
    int we, be, cyc, n;
    logic lk, lost;
    reset = 1'b1; start = 1'b0; stop = 1'b0; num_words = '0;
    clear_masks();
    repeat (3) @(negedge clk);
    check("reset_flags", {tx_en, tx_init, tx_valid, ref_en, ref_init, busy, done, locked, lock_lost, timeout}, 0);
    check("reset_counts", tx_count | rx_count | word_errs | bit_errs, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Clean burst; stop alongside start in IDLE must be ignored
    run_burst(100, 1'b1, -1, -1);
    check_burst("clean", 100, 0, 0);
    check("clean.lock_at", lock_rx, 8);

    // One corrupted word with two flipped bits
    clear_masks();
    mask[20] = 17'h00005;
    run_burst(100, 1'b0, -1, -1);
    check_burst("single_err", 100, 0, 0);

    // Four consecutive bad words after lock: abort
    clear_masks();
    for (int i = 30; i < 34; i++) mask[i] = W'($urandom_range(1, 131071));
    run_burst(200, 1'b0, -1, -1);
    model(200, we, be, lk, lost);
    check("loss.locked", locked, 0);
    check("loss.lock_lost", lock_lost, 1);
    check("loss.fall_seen", fall_seen, 1);
    check("loss.txen_at_fall", fall_txen, 0);
    check("loss.txen_after", post_fall_txen, 0);
    check("loss.tx_count", tx_count, 41);
    check("loss.rx_count", rx_count, 41);
    check("loss.word_errs", word_errs, we);
    check("loss.bit_errs", bit_errs, be);

    // Endless burst, stop after 50 words, nothing returns: drain times out
    clear_masks();
    mon_clr = 1'b1;
    @(negedge clk);
    rx_block = 1'b1; num_words = '0; start = 1'b1; mon_clr = 1'b0;
    @(negedge clk); start = 1'b0;
    repeat (51) @(negedge clk);
    stop = 1'b1; cyc = 0;
    do begin
      @(negedge clk); stop = 1'b0; cyc++;
    end while (!done && cyc < 2000);
    check("to.drain_len", cyc, 1025);
    check("to.timeout", timeout, 1);
    check("to.tx_count", tx_count, 50);
    check("to.rx_count", rx_count, 0);
    check("to.word_errs", word_errs, 0);
    check("to.lock_lost", lock_lost, 0);
    rx_block = 1'b0;
    repeat (3) @(negedge clk);

    // Reset in the middle of a burst, then a full clean burst
    mon_clr = 1'b1;
    @(negedge clk);
    num_words = 100; start = 1'b1; mon_clr = 1'b0;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (tx_count != 37 && cyc < 300) begin @(negedge clk); cyc++; end
    check("rst.reached_37", tx_count, 37);
    reset = 1'b1;
    @(negedge clk);
    check("rst.flags", {tx_en, tx_init, tx_valid, ref_en, ref_init, busy, done, locked, lock_lost, timeout}, 0);
    check("rst.counts", tx_count | rx_count | word_errs | bit_errs, 0);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    run_burst(100, 1'b0, -1, -1);
    check_burst("post_rst", 100, 0, 0);

    // Random lengths with sparse random errors; a start pulse mid-burst is ignored
    for (int b = 0; b < 3; b++) begin
      clear_masks();
      n = $urandom_range(20, 150);
      for (int i = 1; i < n; i++)
        if (mask[i-1] == '0 && $urandom_range(0, 7) == 0) mask[i] = W'($urandom_range(1, 131071));
      run_burst(n, 1'b0, 15, -1);
      check_burst("rand", n, 0, 0);
    end

`ifdef PRBS_BERT_ERR_INJECT_EN
    clear_masks();
    run_burst(100, 1'b0, -1, 40);
    check_burst("inject", 100, 1, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
